// File: rtl/ddr_req_responder_pkg.sv
// ddr_req_responder_pkg: shared DDR request types, widths and FSM encodings
package ddr_req_responder_pkg;
  localparam int DDR_DATA_W = 512;
  localparam int DDR_ADDR_W = 26;
  typedef struct packed {
    logic [DDR_ADDR_W-1:0] addr;
    logic [DDR_DATA_W-1:0] data;
  } ddr_wr_t;
  typedef struct packed {
    logic [DDR_ADDR_W-1:0] addr;
  } ddr_rd_t;
  typedef enum logic [1:0] {IDLE, WR_CMD, RD_CMD} state_e;
  typedef enum logic {LAST_WR, LAST_RD} last_e;
endpackage

// File: rtl/ddr_req_responder_arb.sv
// ddr_req_responder_arb: two-way round-robin between eligible write and read requests
module ddr_req_responder_arb
  import ddr_req_responder_pkg::*;
(
  input  logic  wr_el,
  input  logic  rd_el,
  input  last_e last,
  output logic  pick_wr,
  output logic  pick_rd
);
  assign pick_wr = wr_el && (!rd_el || last == LAST_RD);
  assign pick_rd = rd_el && !pick_wr;
endmodule

// File: rtl/ddr_req_responder_fifo.sv
// ddr_req_responder_fifo: show-ahead request FIFO exposing the head as it will be after this cycle's pop
module ddr_req_responder_fifo #(
  parameter int W      = 8,
  parameter int DEPTH  = 64,
  parameter int AF_GAP = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 head_nxt,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          af_q, af_d, do_push, do_pop;
  // Pushes into a full FIFO are dropped; almost-full reflects the fill after this cycle
  always_comb begin
    do_push  = push && count_q != CW'(DEPTH);
    do_pop   = pop && count_q != '0;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    af_d     = count_d >= CW'(DEPTH - AF_GAP);
  end
  // Pointer, fill and almost-full registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
    end
  end
  // Storage is not reset; the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
  assign head_nxt    = mem_q[rd_ptr_d];
  assign count       = count_q;
  assign almost_full = af_q;
  assign overflow    = push && !do_push;
endmodule

// File: rtl/ddr_req_responder.sv
// ddr_req_responder: arbitrates DDR write/read requests onto a single-beat Avalon-MM master
module ddr_req_responder
  import ddr_req_responder_pkg::*;
#(
  parameter int ADDR_W          = DDR_ADDR_W,
  parameter int REQ_FIFO_DEPTH  = 64,
  parameter int AF_GAP          = 8,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W+DDR_DATA_W-1:0] ddr_wr_req_data,
  input  logic                       ddr_wr_req_valid,
  output logic                       ddr_wr_req_almost_full,
  input  logic [ADDR_W-1:0]          ddr_rd_req_data,
  input  logic                       ddr_rd_req_valid,
  output logic                       ddr_rd_req_almost_full,
  output logic [DDR_DATA_W-1:0]      ddr_rd_resp_data,
  output logic                       ddr_rd_resp_valid,
  input  logic                       ddr_rd_resp_almost_full,
  output logic [ADDR_W-1:0]          mem_address,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [DDR_DATA_W-1:0]      mem_writedata,
  output logic [6:0]                 mem_burstcount,
  input  logic                       mem_waitrequest,
  input  logic [DDR_DATA_W-1:0]      mem_readdata,
  input  logic                       mem_readdatavalid,
  output logic                       err_overflow
);
  localparam int WW = ADDR_W + DDR_DATA_W;
  localparam int CW = $clog2(REQ_FIFO_DEPTH+1);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  state_e                state_q, state_d;
  last_e                 last_q, last_d;
  logic [OW-1:0]         out_q, out_d;
  logic                  mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]     mem_address_q, mem_address_d;
  logic [DDR_DATA_W-1:0] mem_writedata_q, mem_writedata_d, resp_data_q, resp_data_d;
  logic                  resp_valid_q, resp_valid_d, err_q, err_d;
  logic [WW-1:0]         wr_head_nxt;
  logic [ADDR_W-1:0]     rd_head_nxt;
  logic [CW-1:0]         wr_cnt, rd_cnt;
  logic                  wr_ovf, rd_ovf, wr_pop, rd_pop, ret, hold, arbitrate;
  logic                  wr_el, rd_el, pick_wr, pick_rd;
  ddr_req_responder_fifo #(.W(WW), .DEPTH(REQ_FIFO_DEPTH), .AF_GAP(AF_GAP)) u_wr_fifo (
    .clk(clk), .rst_n(rst_n), .push(ddr_wr_req_valid), .din(ddr_wr_req_data), .pop(wr_pop),
    .head_nxt(wr_head_nxt), .count(wr_cnt), .almost_full(ddr_wr_req_almost_full), .overflow(wr_ovf)
  );
  ddr_req_responder_fifo #(.W(ADDR_W), .DEPTH(REQ_FIFO_DEPTH), .AF_GAP(AF_GAP)) u_rd_fifo (
    .clk(clk), .rst_n(rst_n), .push(ddr_rd_req_valid), .din(ddr_rd_req_data), .pop(rd_pop),
    .head_nxt(rd_head_nxt), .count(rd_cnt), .almost_full(ddr_rd_req_almost_full), .overflow(rd_ovf)
  );
  ddr_req_responder_arb u_arb (
    .wr_el(wr_el), .rd_el(rd_el), .last(last_d), .pick_wr(pick_wr), .pick_rd(pick_rd)
  );
  // Eligibility uses post-pop fill and post-update outstanding so an accept can chain into the next command
  always_comb begin
    wr_pop    = mem_write_q && !mem_waitrequest;
    rd_pop    = mem_read_q && !mem_waitrequest;
    ret       = mem_readdatavalid && out_q != '0;
    out_d     = out_q + OW'(rd_pop) - OW'(ret);
    last_d    = wr_pop ? LAST_WR : rd_pop ? LAST_RD : last_q;
    arbitrate = state_q == IDLE || wr_pop || rd_pop;
    hold      = state_q != IDLE && mem_waitrequest;
    wr_el     = arbitrate && wr_cnt > CW'(wr_pop);
    rd_el     = arbitrate && rd_cnt > CW'(rd_pop) && out_d < OW'(MAX_OUTSTANDING) && !ddr_rd_resp_almost_full;
  end
  // Next command and response register contents
  always_comb begin
    state_d         = hold ? state_q : pick_wr ? WR_CMD : pick_rd ? RD_CMD : IDLE;
    mem_write_d     = state_d == WR_CMD;
    mem_read_d      = state_d == RD_CMD;
    mem_address_d   = hold ? mem_address_q : pick_wr ? wr_head_nxt[WW-1 -: ADDR_W] : pick_rd ? rd_head_nxt : '0;
    mem_writedata_d = hold ? mem_writedata_q : pick_wr ? wr_head_nxt[DDR_DATA_W-1:0] : '0;
    resp_valid_d    = ret;
    resp_data_d     = ret ? mem_readdata : resp_data_q;
    err_d           = err_q || wr_ovf || rd_ovf;
  end
  // Command FSM with registered Avalon outputs, outstanding counter and response stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      last_q          <= LAST_RD;
      out_q           <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_q          <= last_d;
      out_q           <= out_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      err_q           <= err_d;
    end
  end
  assign mem_read          = mem_read_q;
  assign mem_write         = mem_write_q;
  assign mem_address       = mem_address_q;
  assign mem_writedata     = mem_writedata_q;
  assign mem_burstcount    = 7'd1;
  assign ddr_rd_resp_valid = resp_valid_q;
  assign ddr_rd_resp_data  = resp_data_q;
  assign err_overflow      = err_q;
endmodule

// File: tb/tb_ddr_req_responder.sv
// tb_ddr_req_responder: directed bench with an Avalon memory model and response scoreboard
module tb_ddr_req_responder;
  import ddr_req_responder_pkg::*;
  localparam int LAT = 5;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [DDR_ADDR_W+DDR_DATA_W-1:0] ddr_wr_req_data = '0;
  logic ddr_wr_req_valid = 1'b0, ddr_wr_req_almost_full;
  logic [DDR_ADDR_W-1:0] ddr_rd_req_data = '0;
  logic ddr_rd_req_valid = 1'b0, ddr_rd_req_almost_full;
  logic [DDR_DATA_W-1:0] ddr_rd_resp_data;
  logic ddr_rd_resp_valid, ddr_rd_resp_almost_full = 1'b0;
  logic [DDR_ADDR_W-1:0] mem_address;
  logic mem_read, mem_write;
  logic [DDR_DATA_W-1:0] mem_writedata;
  logic [6:0] mem_burstcount;
  logic mem_waitrequest = 1'b0;
  logic [DDR_DATA_W-1:0] mem_readdata = '0;
  logic mem_readdatavalid = 1'b0;
  logic err_overflow;
  ddr_req_responder dut (
    .clk(clk), .rst_n(rst_n),
    .ddr_wr_req_data(ddr_wr_req_data), .ddr_wr_req_valid(ddr_wr_req_valid), .ddr_wr_req_almost_full(ddr_wr_req_almost_full),
    .ddr_rd_req_data(ddr_rd_req_data), .ddr_rd_req_valid(ddr_rd_req_valid), .ddr_rd_req_almost_full(ddr_rd_req_almost_full),
    .ddr_rd_resp_data(ddr_rd_resp_data), .ddr_rd_resp_valid(ddr_rd_resp_valid), .ddr_rd_resp_almost_full(ddr_rd_resp_almost_full),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_burstcount(mem_burstcount), .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .err_overflow(err_overflow)
  );
  always #5 clk = ~clk;
  typedef struct {logic [DDR_ADDR_W-1:0] a; int due;} pend_t;
  pend_t pend[$];
  logic [DDR_DATA_W-1:0] mem_model [logic [DDR_ADDR_W-1:0]];
  logic [DDR_DATA_W-1:0] exp_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, resp_cnt = 0, exp_resp = 0, wr_acc = 0, rd_acc = 0;
  logic hold_rdv = 1'b0, alt_chk = 1'b0, alt_have = 1'b0, last_wr = 1'b0, stall_prev = 1'b0;
  logic [575:0] cmd, cmd_prev;
  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [DDR_DATA_W-1:0] pat(input logic [DDR_ADDR_W-1:0] a);
    return {16{6'd0, a}};
  endfunction
  function automatic logic [DDR_DATA_W-1:0] wdat(input int i);
    return {16{32'hC0DE0000 + i}};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_resp(input string tag);
    for (int i = 0; i < 300 && resp_cnt < exp_resp; i++) tick();
    chk(tag, resp_cnt, exp_resp);
  endtask
  task automatic push_rd(input logic [DDR_ADDR_W-1:0] a, input logic [DDR_DATA_W-1:0] d);
    ddr_rd_req_valid = 1'b1;
    ddr_rd_req_data  = a;
    exp_q.push_back(d);
    exp_resp++;
  endtask
  // Avalon slave model and response monitor, evaluated mid-cycle
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      pend.delete();
      mem_readdatavalid = 1'b0;
      stall_prev = 1'b0;
    end else begin
      cyc++;
      if (ddr_rd_resp_valid) begin
        resp_cnt++;
        if (exp_q.size() > 0) chk("resp_data", ddr_rd_resp_data, exp_q.pop_front());
        else chk("resp_extra", ddr_rd_resp_valid, 1'b0);
      end
      if (ddr_rd_resp_valid || mem_readdatavalid) chk("resp_lat", ddr_rd_resp_valid, mem_readdatavalid);
      chk("rw_excl", mem_read & mem_write, 1'b0);
      cmd = {mem_read, mem_write, mem_address, mem_writedata};
      if (stall_prev) chk("cmd_hold", cmd, cmd_prev);
      stall_prev = (mem_read | mem_write) && mem_waitrequest;
      cmd_prev = cmd;
      if (!alt_chk) alt_have = 1'b0;
      if ((mem_read | mem_write) && !mem_waitrequest) begin
        if (alt_chk && alt_have) chk("rr_alt", mem_write, !last_wr);
        alt_have = 1'b1;
        last_wr = mem_write;
        if (mem_write) begin
          mem_model[mem_address] = mem_writedata;
          wr_acc++;
        end else begin
          pend.push_back('{mem_address, cyc + LAT});
          rd_acc++;
        end
      end
      if (!hold_rdv && pend.size() > 0 && pend[0].due <= cyc) begin
        mem_readdatavalid = 1'b1;
        mem_readdata = mem_model.exists(pend[0].a) ? mem_model[pend[0].a] : pat(pend[0].a);
        void'(pend.pop_front());
      end else begin
        mem_readdatavalid = 1'b0;
        mem_readdata = '0;
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int r0, w0;
    repeat (2) @(negedge clk);
    chk("rst_write", mem_write, 1'b0);
    chk("rst_read", mem_read, 1'b0);
    chk("rst_addr", mem_address, 0);
    chk("rst_burst", mem_burstcount, 7'd1);
    chk("rst_err", err_overflow, 1'b0);
    chk("rst_resp", ddr_rd_resp_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    // single write: mem_write only in cycle 2
    ddr_wr_req_data  = {26'h10, {64{8'hA5}}};
    ddr_wr_req_valid = 1'b1;
    tick();
    ddr_wr_req_valid = 1'b0;
    @(negedge clk) chk("wr_c1", mem_write, 1'b0);
    tick();
    @(negedge clk);
    chk("wr_c2", mem_write, 1'b1);
    chk("wr_addr", mem_address, 26'h10);
    chk("wr_data", mem_writedata, {64{8'hA5}});
    tick();
    @(negedge clk) chk("wr_c3", mem_write, 1'b0);
    // read back the same address
    tick();
    push_rd(26'h10, {64{8'hA5}});
    tick();
    ddr_rd_req_valid = 1'b0;
    @(negedge clk) chk("rd_c1", mem_read, 1'b0);
    tick();
    @(negedge clk);
    chk("rd_c2", mem_read, 1'b1);
    chk("rd_addr", mem_address, 26'h10);
    tick();
    wait_resp("rd_resp_cnt");
    chk("rd_outst0", dut.out_q, 0);
    // 20 reads with returns held off: only 16 may issue
    hold_rdv = 1'b1;
    r0 = rd_acc;
    for (int i = 0; i < 20; i++) begin
      push_rd(26'h100 + 26'(i), pat(26'h100 + 26'(i)));
      tick();
    end
    ddr_rd_req_valid = 1'b0;
    repeat (20) tick();
    chk("rd_cap16", rd_acc - r0, 16);
    chk("rd_stall", mem_read, 1'b0);
    hold_rdv = 1'b0;
    wait_resp("rd20_resp");
    chk("rd20_acc", rd_acc - r0, 20);
    chk("rd20_outst0", dut.out_q, 0);
    // both FIFOs full, waitrequest toggling: strict alternation with stable fields
    mem_waitrequest = 1'b1;
    r0 = rd_acc;
    w0 = wr_acc;
    for (int i = 0; i < 64; i++) begin
      ddr_wr_req_valid = 1'b1;
      ddr_wr_req_data  = {26'h200 + 26'(i), wdat(i)};
      push_rd(26'h200 + 26'(i), wdat(i));
      tick();
    end
    ddr_wr_req_valid = 1'b0;
    ddr_rd_req_valid = 1'b0;
    chk("alt_wr_af", ddr_wr_req_almost_full, 1'b1);
    chk("alt_rd_af", ddr_rd_req_almost_full, 1'b1);
    chk("alt_no_ovf", err_overflow, 1'b0);
    alt_chk = 1'b1;
    for (int i = 0; i < 800 && (wr_acc - w0 < 64 || rd_acc - r0 < 64); i++) begin
      mem_waitrequest = !mem_waitrequest;
      tick();
    end
    mem_waitrequest = 1'b0;
    alt_chk = 1'b0;
    chk("alt_wr_acc", wr_acc - w0, 64);
    chk("alt_rd_acc", rd_acc - r0, 64);
    wait_resp("alt_resp");
    // response almost-full blocks issue but not delivery
    hold_rdv = 1'b1;
    r0 = rd_acc;
    for (int i = 0; i < 3; i++) begin
      push_rd(26'h300 + 26'(i), pat(26'h300 + 26'(i)));
      tick();
    end
    ddr_rd_req_valid = 1'b0;
    repeat (10) tick();
    chk("raf_issue3", rd_acc - r0, 3);
    ddr_rd_resp_almost_full = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_rd(26'h310 + 26'(i), pat(26'h310 + 26'(i)));
      tick();
    end
    ddr_rd_req_valid = 1'b0;
    repeat (10) tick();
    chk("raf_blocked", rd_acc - r0, 3);
    chk("raf_no_read", mem_read, 1'b0);
    hold_rdv = 1'b0;
    exp_resp -= 2;
    wait_resp("raf_deliver3");
    chk("raf_still_blk", rd_acc - r0, 3);
    exp_resp += 2;
    ddr_rd_resp_almost_full = 1'b0;
    wait_resp("raf_resume");
    chk("raf_acc5", rd_acc - r0, 5);
    // fill the write FIFO against a stalled slave, then overflow it
    mem_waitrequest = 1'b1;
    for (int n = 1; n <= 65; n++) begin
      ddr_wr_req_valid = 1'b1;
      ddr_wr_req_data  = {26'h400 + 26'(n), wdat(n)};
      tick();
      if (n == 55) chk("af_at55", ddr_wr_req_almost_full, 1'b0);
      if (n == 56) chk("af_at56", ddr_wr_req_almost_full, 1'b1);
      if (n == 64) chk("ovf_at64", err_overflow, 1'b0);
      if (n == 65) chk("ovf_at65", err_overflow, 1'b1);
    end
    ddr_wr_req_valid = 1'b0;
    tick();
    chk("ovf_sticky", err_overflow, 1'b1);
    chk("stall_write", mem_write, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_write", mem_write, 1'b0);
    chk("mid_rst_addr", mem_address, 0);
    chk("mid_rst_wdata", mem_writedata, 0);
    chk("mid_rst_err", err_overflow, 1'b0);
    chk("mid_rst_af", ddr_wr_req_almost_full, 1'b0);
    chk("mid_rst_burst", mem_burstcount, 7'd1);
    tick();
    rst_n = 1'b1;
    mem_waitrequest = 1'b0;
    repeat (5) tick();
    chk("post_rst_idle", mem_write, 1'b0);
    chk("exp_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
